// File: rtl/uart_pattern_tx.sv
// UART test-pattern transmitter: generates increment/decrement/LFSR/constant
// bytes, sends them as 8N1 or 8N2 and leaves an idle gap between frames.
module uart_pattern_tx #(
  parameter int         BAUD       = 115200,
  parameter int         F          = 50000000,
  parameter int         GAP_CYCLES = 1000,
  parameter int         STOP_BITS  = 1,
  parameter logic [7:0] LFSR_SEED  = 8'h01,
  parameter int         CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [7:0]       limit,
  input  logic [7:0]       const_byte,
  output logic             tx,
  output logic             busy,
  output logic             frame_done,
  output logic [7:0]       cur_byte,
  output logic [CNT_W-1:0] frame_cnt
);

  localparam int CPB      = F / BAUD;
  localparam int STOP_LEN = STOP_BITS * CPB;
  localparam int GAP_LAST = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;
  localparam int TMAX     = (STOP_LEN > GAP_CYCLES) ? STOP_LEN : GAP_CYCLES;
  localparam int TW       = $clog2(TMAX + 1);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, GAP} state_t;

  state_t        state, state_n;
  logic [TW-1:0] timer, timer_n;
  logic [2:0]    bit_idx, bit_n;
  logic [7:0]    shift, shift_n;
  logic [7:0]    pat, lfsr;
  logic [7:0]    lfsr_src, ld_byte, ld_pat, ld_lfsr;
  logic          load;
  logic          tx_n, busy_n, done_n;

  // Byte selection and sequence advance, applied only when load is taken.
  always_comb begin
    lfsr_src = (lfsr == 8'h00) ? LFSR_SEED : lfsr;
    ld_byte  = const_byte;
    ld_pat   = pat;
    ld_lfsr  = lfsr;
    unique case (mode)
      2'd0: begin
        ld_byte = pat;
        ld_pat  = (pat >= limit) ? 8'h00 : pat + 8'h01;
      end
      2'd1: begin
        ld_byte = pat;
        ld_pat  = (pat == 8'h00 || pat > limit) ? limit : pat - 8'h01;
      end
      2'd2: begin
        ld_byte = lfsr_src;
        ld_lfsr = {lfsr_src[6:0], lfsr_src[7] ^ lfsr_src[5] ^ lfsr_src[4] ^ lfsr_src[3]};
      end
      default: ld_byte = const_byte;
    endcase
  end

  // Frame sequencer; outputs are derived from the next state so they register cleanly.
  always_comb begin
    state_n = state;
    timer_n = timer + TW'(1);
    bit_n   = bit_idx;
    shift_n = shift;
    load    = 1'b0;
    unique case (state)
      IDLE: begin
        timer_n = '0;
        if (en) begin
          load    = 1'b1;
          state_n = START;
        end
      end
      START: begin
        if (timer == TW'(CPB - 1)) begin
          timer_n = '0;
          bit_n   = 3'd0;
          state_n = DATA;
        end
      end
      DATA: begin
        if (timer == TW'(CPB - 1)) begin
          timer_n = '0;
          if (bit_idx == 3'd7) begin
            state_n = STOP;
          end else begin
            bit_n   = bit_idx + 3'd1;
            shift_n = shift >> 1;
          end
        end
      end
      STOP: begin
        if (timer == TW'(STOP_LEN - 1)) begin
          timer_n = '0;
          if (en && GAP_CYCLES > 0) begin
            state_n = GAP;
          end else if (en) begin
            load    = 1'b1;
            state_n = START;
          end else begin
            state_n = IDLE;
          end
        end
      end
      GAP: begin
        if (!en) begin
          timer_n = '0;
          state_n = IDLE;
        end else if (timer == TW'(GAP_LAST)) begin
          timer_n = '0;
          load    = 1'b1;
          state_n = START;
        end
      end
      default: begin
        timer_n = '0;
        state_n = IDLE;
      end
    endcase
    if (load) shift_n = ld_byte;

    tx_n   = 1'b1;
    if (state_n == START) tx_n = 1'b0;
    if (state_n == DATA)  tx_n = shift_n[0];
    busy_n = (state_n == START) || (state_n == DATA) || (state_n == STOP);
    done_n = (state_n == STOP) && (timer_n == TW'(STOP_LEN - 1));
  end

  // State, sequence registers and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      timer      <= '0;
      bit_idx    <= '0;
      shift      <= '0;
      pat        <= '0;
      lfsr       <= LFSR_SEED;
      tx         <= 1'b1;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      cur_byte   <= '0;
      frame_cnt  <= '0;
    end else begin
      state      <= state_n;
      timer      <= timer_n;
      bit_idx    <= bit_n;
      shift      <= shift_n;
      tx         <= tx_n;
      busy       <= busy_n;
      frame_done <= done_n;
      if (load) begin
        pat      <= ld_pat;
        lfsr     <= ld_lfsr;
        cur_byte <= ld_byte;
      end
      if (done_n) frame_cnt <= frame_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_uart_pattern_tx.sv
// Scoreboard bench for uart_pattern_tx: dut0 is 8N1 with an 8-cycle gap,
// dut1 is 8N2 with no gap; both run at 4 clocks per bit.
module tb_uart_pattern_tx;
  localparam int         CPB  = 4;
  localparam logic [7:0] SEED = 8'h01;

  logic        clk   = 1'b0;
  logic [1:0]  rst_v = 2'b11;
  logic [1:0]  en_v  = 2'b00;
  logic [1:0]  mode  = 2'd0;
  logic [7:0]  limit = 8'd0;
  logic [7:0]  cbyte = 8'd0;
  logic        tx0, tx1, busy0, busy1, fd0, fd1;
  logic [7:0]  cur0, cur1;
  logic [15:0] fc0, fc1;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int done_cnt [2] = '{0, 0};
  int fd_len   [2] = '{0, 0};
  int run_id   [2] = '{0, 0};
  int exp_fc   [2] = '{0, 0};
  logic [7:0] m_pat  [2];
  logic [7:0] m_lfsr [2];
  logic [7:0] q0 [$];
  logic [7:0] q1 [$];

  always #5 clk = ~clk;

  uart_pattern_tx #(.BAUD(100), .F(400), .GAP_CYCLES(8), .STOP_BITS(1),
                    .LFSR_SEED(SEED), .CNT_W(16)) dut0 (
    .clk(clk), .rst(rst_v[0]), .en(en_v[0]), .mode(mode), .limit(limit),
    .const_byte(cbyte), .tx(tx0), .busy(busy0), .frame_done(fd0),
    .cur_byte(cur0), .frame_cnt(fc0));

  uart_pattern_tx #(.BAUD(100), .F(400), .GAP_CYCLES(0), .STOP_BITS(2),
                    .LFSR_SEED(SEED), .CNT_W(16)) dut1 (
    .clk(clk), .rst(rst_v[1]), .en(en_v[1]), .mode(mode), .limit(limit),
    .const_byte(cbyte), .tx(tx1), .busy(busy1), .frame_done(fd1),
    .cur_byte(cur1), .frame_cnt(fc1));

  function automatic logic tx_of(input int id);   return (id == 0) ? tx0 : tx1;     endfunction
  function automatic logic busy_of(input int id); return (id == 0) ? busy0 : busy1; endfunction
  function automatic logic fd_of(input int id);   return (id == 0) ? fd0 : fd1;     endfunction
  function automatic logic [7:0] cur_of(input int id); return (id == 0) ? cur0 : cur1; endfunction
  function automatic logic [15:0] fc_of(input int id); return (id == 0) ? fc0 : fc1;   endfunction
  function automatic int q_size(input int id); return (id == 0) ? q0.size() : q1.size(); endfunction
  function automatic logic [7:0] q_pop(input int id);
    return (id == 0) ? q0.pop_front() : q1.pop_front();
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference sequence generator; pushes the next expected byte for a DUT.
  task automatic push_exp(input int id);
    logic [7:0] b, s;
    b = cbyte;
    case (mode)
      2'd0: begin
        b = m_pat[id];
        m_pat[id] = (m_pat[id] >= limit) ? 8'd0 : m_pat[id] + 8'd1;
      end
      2'd1: begin
        b = m_pat[id];
        m_pat[id] = (m_pat[id] == 8'd0 || m_pat[id] > limit) ? limit : m_pat[id] - 8'd1;
      end
      2'd2: begin
        s = (m_lfsr[id] == 8'd0) ? SEED : m_lfsr[id];
        b = s;
        m_lfsr[id] = {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
      end
      default: b = cbyte;
    endcase
    if (id == 0) q0.push_back(b); else q1.push_back(b);
  endtask

  // Line monitor: on each start bit, pops the expected byte and checks the
  // whole frame cycle by cycle (line level, busy, frame_done), the decoded
  // byte, cur_byte and the start-to-start period inside one run.
  task automatic monitor(input int id, input int nstop, input int period);
    logic       prev, lvl, abort;
    logic [7:0] e, rx, cur;
    int         t0, last_t, last_run, errs, flen;
    prev = 1'b1; last_t = -1; last_run = -1;
    flen = (9 + nstop) * CPB;
    forever begin
      @(negedge clk);
      if (prev === 1'b1 && tx_of(id) === 1'b0 && !rst_v[id]) begin
        t0 = cyc; rx = '0; errs = 0; abort = 1'b0; cur = cur_of(id);
        if (q_size(id) == 0) begin
          chk($sformatf("sb_empty%0d", id), 1, 0);
          e = '0;
        end else begin
          e = q_pop(id);
        end
        if (last_t >= 0 && last_run == run_id[id])
          chk($sformatf("period%0d", id), t0 - last_t, period);
        last_t = t0; last_run = run_id[id];
        for (int j = 0; j < flen; j++) begin
          if (j > 0) @(negedge clk);
          if (rst_v[id]) begin abort = 1'b1; break; end
          lvl = (j < CPB) ? 1'b0 : (j < 9 * CPB) ? e[j / CPB - 1] : 1'b1;
          if (tx_of(id) !== lvl) errs++;
          if (busy_of(id) !== 1'b1) errs++;
          if (fd_of(id) !== (j == flen - 1)) errs++;
          if (j >= CPB && j < 9 * CPB && (j % CPB) == CPB / 2) rx[j / CPB - 1] = tx_of(id);
        end
        if (!abort) begin
          chk($sformatf("wave%0d byte %0h", id, e), errs, 0);
          chk($sformatf("rx_byte%0d", id), rx, e);
          chk($sformatf("cur_byte%0d", id), cur, e);
        end
      end
      prev = tx_of(id);
    end
  endtask

  initial monitor(0, 1, 48);
  initial monitor(1, 2, 44);

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // frame_done pulse counter and width check.
  initial forever begin
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      if (fd_of(i) === 1'b1) begin
        if (fd_len[i] == 0) done_cnt[i]++;
        fd_len[i]++;
      end else if (fd_len[i] != 0) begin
        chk($sformatf("fd_len%0d", i), fd_len[i], 1);
        fd_len[i] = 0;
      end
    end
  end

  task automatic wait_done(input int id, input int target);
    int n;
    n = 0;
    while (done_cnt[id] < target && n < 2000) begin tick(); n++; end
    if (done_cnt[id] < target) chk($sformatf("timeout_done%0d", id), done_cnt[id], target);
  endtask

  task automatic wait_busy(input int id);
    int n;
    n = 0;
    while (busy_of(id) !== 1'b1 && n < 200) begin tick(); n++; end
    if (busy_of(id) !== 1'b1) chk($sformatf("timeout_busy%0d", id), 0, 1);
  endtask

  // Park inside the DATA phase of the frame that is starting.
  task automatic drop_in_data(input int id);
    wait_busy(id);
    repeat (2 * CPB) tick();
  endtask

  task automatic reset_dut(input int id);
    en_v[id]  = 1'b0;
    rst_v[id] = 1'b1;
    tick();
    tick();
    rst_v[id] = 1'b0;
    m_pat[id] = 8'd0; m_lfsr[id] = SEED; exp_fc[id] = 0; run_id[id]++;
    if (id == 0) q0.delete(); else q1.delete();
    chk($sformatf("rst_tx%0d", id), tx_of(id), 1);
    chk($sformatf("rst_busy%0d", id), busy_of(id), 0);
    chk($sformatf("rst_fd%0d", id), fd_of(id), 0);
    chk($sformatf("rst_cur%0d", id), cur_of(id), 0);
    chk($sformatf("rst_fc%0d", id), fc_of(id), 0);
  endtask

  // After en has been dropped: last frame completes, line idles, counts agree.
  task automatic finish_run(input int id, input int base, input int n);
    int errs;
    errs = 0;
    wait_done(id, base + n);
    for (int k = 0; k < 3 * CPB + 12; k++) begin
      tick();
      if (tx_of(id) !== 1'b1 || busy_of(id) !== 1'b0) errs++;
    end
    exp_fc[id] += n;
    chk($sformatf("idle%0d", id), errs, 0);
    chk($sformatf("done_cnt%0d", id), done_cnt[id] - base, n);
    chk($sformatf("sb_left%0d", id), q_size(id), 0);
    chk($sformatf("frame_cnt%0d", id), fc_of(id), exp_fc[id] % 65536);
  endtask

  // Stream n frames with current settings; en drops during DATA of the last.
  task automatic run(input int id, input int n);
    int base;
    base = done_cnt[id];
    for (int k = 0; k < n; k++) push_exp(id);
    run_id[id]++;
    en_v[id] = 1'b1;
    wait_done(id, base + n - 1);
    drop_in_data(id);
    en_v[id] = 1'b0;
    finish_run(id, base, n);
  endtask

  initial begin
    int base;
    m_pat  = '{8'd0, 8'd0};
    m_lfsr = '{SEED, SEED};

    // Incrementing count with wrap at limit, 48-clock period.
    reset_dut(0);
    mode = 2'd0; limit = 8'd7;
    run(0, 10);

    // LFSR sequence, then mode 0 resumes its untouched counter.
    reset_dut(0);
    mode = 2'd2;
    run(0, 5);
    mode = 2'd0; limit = 8'd7;
    run(0, 2);

    // Decrement with limit 3, then constant mode applied mid-frame.
    reset_dut(0);
    mode = 2'd1; limit = 8'd3;
    base = done_cnt[0];
    repeat (6) push_exp(0);
    run_id[0]++;
    en_v[0] = 1'b1;
    wait_done(0, base + 5);
    drop_in_data(0);
    mode = 2'd3; cbyte = 8'hA5;
    repeat (3) push_exp(0);
    wait_done(0, base + 8);
    drop_in_data(0);
    en_v[0] = 1'b0;
    finish_run(0, base, 9);

    // Stop during byte 5, restart continues at 6.
    reset_dut(0);
    mode = 2'd0; limit = 8'd7;
    run(0, 6);
    run(0, 2);

    // limit = 0 in both counting modes, then lowering limit below pat.
    reset_dut(0);
    mode = 2'd0; limit = 8'd0;
    run(0, 3);
    mode = 2'd1;
    run(0, 3);
    mode = 2'd0; limit = 8'd7;
    run(0, 5);
    limit = 8'd2;
    run(0, 3);

    // Reset during DATA bit 3 aborts the frame and reinitialises the LFSR.
    reset_dut(0);
    mode = 2'd2;
    run(0, 2);
    push_exp(0);
    run_id[0]++;
    en_v[0] = 1'b1;
    wait_busy(0);
    repeat (4 * CPB + 1) tick();
    rst_v[0] = 1'b1;
    tick();
    rst_v[0] = 1'b0;
    en_v[0]  = 1'b0;
    chk("mid_rst_tx", tx0, 1);
    chk("mid_rst_busy", busy0, 0);
    chk("mid_rst_fc", fc0, 0);
    m_pat[0] = 8'd0; m_lfsr[0] = SEED; exp_fc[0] = 0; run_id[0]++;
    q0.delete();
    run(0, 2);

    // Two stop bits, no gap: back-to-back 44-clock frames.
    reset_dut(1);
    mode = 2'd0; limit = 8'd7;
    run(1, 4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #800000;
    $display("FAIL watchdog: simulation did not finish, %0d tests run", n_tests);
    $fatal(1, "watchdog expired");
  end

endmodule
